// File: rtl/serial_compare_lsb.sv
// ----------------------------------------------------------------------------
// serial_compare_lsb : bit-serial unsigned magnitude comparator, LSB first
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_compare_lsb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    V_EQ = 2'd0,
    V_GT = 2'd1,
    V_LT = 2'd2
  } verdict_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  verdict_t         r_verdict;
  verdict_t         w_verdict;
  logic             w_last;

  // Later (higher) bits overwrite the verdict, so the MSB difference wins.
  always_comb begin
    w_verdict = r_verdict;
    if (r_a[0] && !r_b[0]) begin
      w_verdict = V_GT;
    end else if (!r_a[0] && r_b[0]) begin
      w_verdict = V_LT;
    end
  end

  assign w_last = (r_cnt == C_LAST);

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != IDLE);
    done         = (r_state == DONE);
    case (r_state)
      IDLE:    if (start) w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_verdict <= V_EQ;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_cnt     <= '0;
            r_verdict <= V_EQ;
          end
        end
        SHIFT: begin
          r_a       <= r_a >> 1;
          r_b       <= r_b >> 1;
          r_verdict <= w_verdict;
          r_cnt     <= w_last ? '0 : r_cnt + CW'(1);
          // Result registers only move on the edge that enters DONE.
          if (w_last) begin
            gt <= (w_verdict == V_GT);
            lt <= (w_verdict == V_LT);
            eq <= (w_verdict == V_EQ);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_compare_lsb.sv
// ----------------------------------------------------------------------------
// tb_serial_compare_lsb : directed self-checking bench (WIDTH=8 and WIDTH=2)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_compare_lsb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, gt, lt, eq;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       busy2, done2, gt2, lt2, eq2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_compare_lsb #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq)
  );

  serial_compare_lsb #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .gt(gt2), .lt(lt2), .eq(eq2)
  );

  // One full 8-bit transaction; exp is {gt,lt,eq}.
  task automatic do_cmp(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [2:0] exp, input string nm);
    int n;
    int busy_cnt;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s idle_before: busy=%b want 0", nm, busy);
    else n_pass++;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tb_v;
    n = 0; busy_cnt = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (busy === 1'b1) busy_cnt++;
    n_checks++;
    if (n !== 8) $display("FAIL %s latency: got %0d want 8", nm, n);
    else n_pass++;
    n_checks++;
    if ({gt, lt, eq} !== exp) $display("FAIL %s result: gt/lt/eq=%b want %b", nm, {gt, lt, eq}, exp);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) $display("FAIL %s after_done: done/busy=%b want 00", nm, {done, busy});
    else n_pass++;
    n_checks++;
    if (busy_cnt !== 9) $display("FAIL %s busy_cycles: got %0d want 9", nm, busy_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy, done, gt, lt, eq} !== 5'b0) $display("FAIL reset8: busy/done/gt/lt/eq=%b want 00000", {busy, done, gt, lt, eq});
    else n_pass++;
    n_checks++;
    if ({busy2, done2, gt2, lt2, eq2} !== 5'b0) $display("FAIL reset2: busy/done/gt/lt/eq=%b want 00000", {busy2, done2, gt2, lt2, eq2});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_cmp(8'hA5, 8'h5A, 3'b100, "a5_5a");
  endtask

  task automatic test_msb_override();
    do_cmp(8'h01, 8'h80, 3'b010, "01_80");
    do_cmp(8'h80, 8'h7F, 3'b100, "80_7f");
  endtask

  task automatic test_equal();
    do_cmp(8'h3C, 8'h3C, 3'b001, "3c_3c");
    do_cmp(8'h00, 8'h00, 3'b001, "00_00");
  endtask

  task automatic test_hold();
    do_cmp(8'hFE, 8'hFF, 3'b010, "fe_ff");
    repeat (4) @(negedge clk);
    n_checks++;
    if ({gt, lt, eq} !== 3'b010) $display("FAIL hold_idle: gt/lt/eq=%b want 010", {gt, lt, eq});
    else n_pass++;
    start = 1'b1; a = 8'hC0; b = 8'h03;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({gt, lt, eq} !== 3'b010) $display("FAIL hold_shift: gt/lt/eq=%b want 010", {gt, lt, eq});
    else n_pass++;
    repeat (6) @(negedge clk);
    n_checks++;
    if ({gt, lt, eq} !== 3'b100) $display("FAIL hold_next: gt/lt/eq=%b want 100", {gt, lt, eq});
    else n_pass++;
  endtask

  // start held high and operands rotating every cycle through three pairs.
  // Edge 0 accepts; DONE follows edge 8, IDLE follows edge 9, next accept at
  // edge 10, so the accepted pair index advances by 10 mod 3 = 1 each time.
  task automatic test_back_to_back();
    logic [7:0] ta [3];
    logic [7:0] tb_v [3];
    logic [2:0] te [3];
    int errs_done, errs_busy;
    ta[0] = 8'h10; tb_v[0] = 8'h20; te[0] = 3'b010;
    ta[1] = 8'hF0; tb_v[1] = 8'h0F; te[1] = 3'b100;
    ta[2] = 8'h55; tb_v[2] = 8'h55; te[2] = 3'b001;
    errs_done = 0; errs_busy = 0;
    @(negedge clk);
    for (int i = 0; i <= 30; i++) begin
      if (i >= 1) begin
        if (busy !== (i % 10 != 0)) errs_busy++;
        if (done !== (i % 10 == 9)) errs_done++;
        if (i % 10 == 9) begin
          n_checks++;
          if ({gt, lt, eq} !== te[((i - 9) / 10) % 3])
            $display("FAIL b2b_result@%0d: gt/lt/eq=%b want %b", i, {gt, lt, eq}, te[((i - 9) / 10) % 3]);
          else n_pass++;
        end
      end
      if (i == 30) start = 1'b0;
      else begin
        start = 1'b1; a = ta[i % 3]; b = tb_v[i % 3];
      end
      @(negedge clk);
    end
    n_checks++;
    if (errs_busy !== 0) $display("FAIL b2b_busy: %0d cycles wrong want 0", errs_busy);
    else n_pass++;
    n_checks++;
    if (errs_done !== 0) $display("FAIL b2b_done: %0d cycles wrong want 0", errs_done);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL b2b_stop: busy=%b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, gt, lt, eq} !== 5'b0) $display("FAIL abort: busy/done/gt/lt/eq=%b want 00000", {busy, done, gt, lt, eq});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL abort_quiet: %0d active cycles want 0", seen);
    else n_pass++;
    do_cmp(8'h00, 8'h01, 3'b010, "after_abort");
  endtask

  task automatic test_width2();
    int bad_lat, bad_res, n;
    logic [2:0] exp;
    bad_lat = 0; bad_res = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a2 = 2'(i >> 2); b2 = 2'(i & 3); start2 = 1'b1;
      exp = {(i >> 2) > (i & 3), (i >> 2) < (i & 3), (i >> 2) == (i & 3)};
      @(negedge clk);
      start2 = 1'b0; a2 = ~a2; b2 = ~b2;
      n = 0;
      while (done2 !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (n != 2) bad_lat++;
      if ({gt2, lt2, eq2} !== exp) begin
        bad_res++;
        $display("FAIL w2_pair a=%0d b=%0d: gt/lt/eq=%b want %b", i >> 2, i & 3, {gt2, lt2, eq2}, exp);
      end
    end
    n_checks++;
    if (bad_lat !== 0) $display("FAIL w2_latency: %0d pairs wrong want 0", bad_lat);
    else n_pass++;
    n_checks++;
    if (bad_res !== 0) $display("FAIL w2_results: %0d pairs wrong want 0", bad_res);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_msb_override();
    test_equal();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    test_width2();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
